// File: rtl/slink_tx_credit_ctrl_pkg.sv
// rtl/slink_tx_credit_ctrl_pkg.sv - credit counter next-state helpers for slink_tx_credit_ctrl
package slink_tx_credit_ctrl_pkg;

    // Reload wins; a return at the ceiling saturates instead of wrapping.
    function automatic int unsigned credit_next(
        input int unsigned cnt,
        input logic        consume,
        input logic        ret,
        input logic        reload,
        input int unsigned max_credits
    );
        if (reload) begin
            return max_credits;
        end
        if (consume && !ret) begin
            return cnt - 1;
        end
        if (ret && !consume && (cnt < max_credits)) begin
            return cnt + 1;
        end
        return cnt;
    endfunction

    function automatic logic credit_overflow_next(
        input logic        ovf,
        input int unsigned cnt,
        input logic        consume,
        input logic        ret,
        input logic        reload,
        input int unsigned max_credits
    );
        if (reload) begin
            return 1'b0;
        end
        return ovf | (ret & ~consume & (cnt == max_credits));
    endfunction

endpackage

// File: rtl/slink_tx_credit_ctrl_stream_register.sv
// rtl/slink_tx_credit_ctrl_stream_register.sv - single-entry valid/ready register with pass-through ready
module slink_tx_credit_ctrl_stream_register #(
    parameter type T = logic
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic valid_i,
    output logic ready_o,
    input  T     data_i,
    output logic valid_o,
    input  logic ready_i,
    output T     data_o
);

    logic reg_ena;

    assign ready_o = ready_i | ~valid_o;
    assign reg_ena = valid_i & ready_o;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_o <= 1'b0;
        end else if (ready_o) begin
            valid_o <= valid_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_o <= '0;
        end else if (reg_ena) begin
            data_o <= data_i;
        end
    end

endmodule

// File: rtl/slink_tx_credit_ctrl.sv
// rtl/slink_tx_credit_ctrl.sv - credit-based flow-control gate on the serial-link TX path
module slink_tx_credit_ctrl
    import slink_tx_credit_ctrl_pkg::*;
#(
    parameter type         phy_data_t  = logic,
    parameter int unsigned NumChannels = 1,
    parameter int unsigned NumCredits  = 8,
    localparam int unsigned CntWidth   = $clog2(NumCredits + 1)
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  phy_data_t [NumChannels-1:0]       data_in_i,
    input  logic      [NumChannels-1:0]       data_in_valid_i,
    output logic                              data_in_ready_o,
    output phy_data_t [NumChannels-1:0]       data_out_o,
    output logic      [NumChannels-1:0]       data_out_valid_o,
    input  logic                              data_out_ready_i,
    input  logic                              credit_return_i,
    input  logic                              cfg_credit_bypass_i,
    input  logic                              cfg_credit_reload_i,
    output logic      [CntWidth-1:0]          credits_o,
    output logic                              credit_stall_o,
    output logic                              credit_overflow_o
);

    typedef phy_data_t [NumChannels-1:0] beat_t;

    logic [NumChannels-1:0] out_valid_q;
    logic [CntWidth-1:0]    cnt_q, cnt_d;
    logic                   ovf_q, ovf_d;
    logic                   space, credit_ok, offered, accept, consume;
    logic                   reg_valid;

    assign offered         = |data_in_valid_i;
    assign credit_ok       = cfg_credit_bypass_i | (cnt_q != '0);
    assign data_in_ready_o = space & credit_ok;
    assign accept          = offered & data_in_ready_o;
    assign consume         = accept & ~cfg_credit_bypass_i;
    assign credit_stall_o  = offered & space & ~credit_ok;

    // Register's ready is ready_i | ~valid, i.e. the empty-or-draining space term.
    slink_tx_credit_ctrl_stream_register #(
        .T (beat_t)
    ) i_out_reg (
        .clk_i   (clk_i),
        .rst_ni  (~rst_i),
        .valid_i (offered & credit_ok),
        .ready_o (space),
        .data_i  (data_in_i),
        .valid_o (reg_valid),
        .ready_i (data_out_ready_i),
        .data_o  (data_out_o)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            out_valid_q <= '0;
        end else if (accept) begin
            out_valid_q <= data_in_valid_i;
        end else if (data_out_ready_i) begin
            out_valid_q <= '0;
        end
    end

    assign data_out_valid_o = reg_valid ? out_valid_q : '0;

    always_comb begin
        cnt_d = CntWidth'(credit_next(int'(cnt_q), consume, credit_return_i,
                                      cfg_credit_reload_i, NumCredits));
        ovf_d = credit_overflow_next(ovf_q, int'(cnt_q), consume, credit_return_i,
                                     cfg_credit_reload_i, NumCredits);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= CntWidth'(NumCredits);
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    assign credits_o         = cnt_q;
    assign credit_overflow_o = ovf_q;

endmodule

// File: tb/tb_slink_tx_credit_ctrl.sv
// tb/tb_slink_tx_credit_ctrl.sv - self-checking bench for slink_tx_credit_ctrl
module tb_slink_tx_credit_ctrl;

    typedef logic [7:0] byte_t;
    localparam int NCH = 2;
    localparam int NCR = 4;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [NCH-1:0][7:0]   data_in = '0;
    logic [NCH-1:0]        vin = '0;
    logic                  in_ready;
    logic [NCH-1:0][7:0]   data_out;
    logic [NCH-1:0]        vout;
    logic                  out_ready = 1'b0;
    logic                  ret = 1'b0;
    logic                  bypass = 1'b0;
    logic                  reload = 1'b0;
    logic [2:0]            credits;
    logic                  stall;
    logic                  ovf;

    int n_checks = 0;
    int n_pass   = 0;
    logic [17:0] sb[$];

    always #5 clk = ~clk;

    slink_tx_credit_ctrl #(
        .phy_data_t  (byte_t),
        .NumChannels (NCH),
        .NumCredits  (NCR)
    ) dut (
        .clk_i               (clk),
        .rst_i               (rst),
        .data_in_i           (data_in),
        .data_in_valid_i     (vin),
        .data_in_ready_o     (in_ready),
        .data_out_o          (data_out),
        .data_out_valid_o    (vout),
        .data_out_ready_i    (out_ready),
        .credit_return_i     (ret),
        .cfg_credit_bypass_i (bypass),
        .cfg_credit_reload_i (reload),
        .credits_o           (credits),
        .credit_stall_o      (stall),
        .credit_overflow_o   (ovf)
    );

    // Pops the scoreboard on every output handshake, then advances to the next falling edge.
    task automatic tick();
        logic [17:0] exp;
        #1;
        if (vout != '0 && out_ready) begin
            n_checks++;
            if (sb.size() == 0) begin
                $display("FAIL sb_unexpected: got %h want no beat", {vout, data_out});
            end else begin
                exp = sb.pop_front();
                if ({vout, data_out} !== exp) $display("FAIL sb_beat: got %h want %h", {vout, data_out}, exp);
                else n_pass++;
            end
        end
        @(negedge clk);
    endtask

    task automatic offer(input logic [1:0] m, input logic [15:0] d);
        vin     = m;
        data_in = d;
        sb.push_back({m, d});
    endtask

    task automatic drain_check(input string name);
        vin       = '0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        n_checks++;
        if (sb.size() != 0) $display("FAIL %s: got %0d beats left want 0", name, sb.size());
        else n_pass++;
    endtask

    task automatic test_reset();
        #1;
        n_checks++; if ({vout, data_out} !== 18'h0) $display("FAIL reset_out: got %h want 0", {vout, data_out}); else n_pass++;
        n_checks++; if (credits !== 3'd4) $display("FAIL reset_credits: got %0d want 4", credits); else n_pass++;
        n_checks++; if (ovf !== 1'b0) $display("FAIL reset_ovf: got %b want 0", ovf); else n_pass++;
        rst = 1'b0;
        #1;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", in_ready); else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_exhaustion();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            offer(2'b01, 16'(16'h0010 + i));
            #1;
            n_checks++; if (credits !== 3'(4 - i)) $display("FAIL exh_credits%0d: got %0d want %0d", i, credits, 4 - i); else n_pass++;
            n_checks++; if (in_ready !== 1'b1) $display("FAIL exh_ready%0d: got %b want 1", i, in_ready); else n_pass++;
            if (i > 0) begin
                n_checks++; if (vout !== 2'b01) $display("FAIL exh_b2b%0d: got %b want 01", i, vout); else n_pass++;
            end
            tick();
        end
        offer(2'b01, 16'h0014);
        #1;
        n_checks++; if ({in_ready, stall, credits} !== {1'b0, 1'b1, 3'd0}) $display("FAIL exh_stall: got %b want 01000", {in_ready, stall, credits}); else n_pass++;
        n_checks++; if (vout !== 2'b01) $display("FAIL exh_last: got %b want 01", vout); else n_pass++;
        tick();
        #1;
        n_checks++; if ({in_ready, stall} !== 2'b01) $display("FAIL exh_stall2: got %b want 01", {in_ready, stall}); else n_pass++;
        tick();
    endtask

    task automatic test_return();
        ret = 1'b1;
        #1;
        n_checks++; if ({in_ready, credits} !== {1'b0, 3'd0}) $display("FAIL ret_same_cycle: got %b want 0000", {in_ready, credits}); else n_pass++;
        tick();
        ret = 1'b0;
        #1;
        n_checks++; if ({in_ready, credits} !== {1'b1, 3'd1}) $display("FAIL ret_next_cycle: got %b want 1001", {in_ready, credits}); else n_pass++;
        tick();
        offer(2'b11, 16'hB615);
        #1;
        n_checks++; if ({credits, stall, vout} !== {3'd0, 1'b1, 2'b01}) $display("FAIL ret_after: got %b want 000101", {credits, stall, vout}); else n_pass++;
        tick();
        ret = 1'b1;
        tick();
        ret = 1'b0;
        #1;
        n_checks++; if ({in_ready, credits} !== {1'b1, 3'd1}) $display("FAIL ret_second: got %b want 1001", {in_ready, credits}); else n_pass++;
        tick();
        vin = '0;
        #1;
        n_checks++; if (credits !== 3'd0) $display("FAIL ret_consumed: got %0d want 0", credits); else n_pass++;
        drain_check("ret_drain");
    endtask

    task automatic test_simultaneous();
        ret = 1'b1;
        tick();
        tick();
        ret = 1'b0;
        #1;
        n_checks++; if (credits !== 3'd2) $display("FAIL sim_start: got %0d want 2", credits); else n_pass++;
        ret = 1'b1;
        for (int i = 0; i < 4; i++) begin
            offer(2'b10, 16'({8'h20 + 8'(i), 8'h00}));
            #1;
            n_checks++; if ({in_ready, credits} !== {1'b1, 3'd2}) $display("FAIL sim_cycle%0d: got %b want 1010", i, {in_ready, credits}); else n_pass++;
            if (i > 0) begin
                n_checks++; if (vout !== 2'b10) $display("FAIL sim_b2b%0d: got %b want 10", i, vout); else n_pass++;
            end
            tick();
        end
        ret = 1'b0;
        vin = '0;
        #1;
        n_checks++; if (credits !== 3'd2) $display("FAIL sim_end: got %0d want 2", credits); else n_pass++;
        drain_check("sim_drain");
    endtask

    task automatic test_overflow();
        ret = 1'b1;
        tick();
        tick();
        ret = 1'b0;
        #1;
        n_checks++; if ({credits, ovf} !== {3'd4, 1'b0}) $display("FAIL ovf_full: got %b want 1000", {credits, ovf}); else n_pass++;
        ret = 1'b1;
        tick();
        ret = 1'b0;
        #1;
        n_checks++; if ({credits, ovf} !== {3'd4, 1'b1}) $display("FAIL ovf_set: got %b want 1001", {credits, ovf}); else n_pass++;
        tick();
        tick();
        #1;
        n_checks++; if (ovf !== 1'b1) $display("FAIL ovf_sticky: got %b want 1", ovf); else n_pass++;
        reload = 1'b1;
        tick();
        reload = 1'b0;
        #1;
        n_checks++; if ({credits, ovf} !== {3'd4, 1'b0}) $display("FAIL ovf_reload: got %b want 1000", {credits, ovf}); else n_pass++;
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        offer(2'b01, 16'h00A5);
        #1;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL bp_first: got %b want 1", in_ready); else n_pass++;
        tick();
        offer(2'b01, 16'h005A);
        for (int i = 0; i < 5; i++) begin
            #1;
            n_checks++;
            if ({vout, data_out, in_ready, stall, credits} !== {2'b01, 16'h00A5, 1'b0, 1'b0, 3'd3})
                $display("FAIL bp_hold%0d: got %h want %h", i, {vout, data_out, in_ready, stall, credits}, {2'b01, 16'h00A5, 1'b0, 1'b0, 3'd3});
            else n_pass++;
            tick();
        end
        out_ready = 1'b1;
        #1;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL bp_passthru: got %b want 1", in_ready); else n_pass++;
        tick();
        vin = '0;
        #1;
        n_checks++; if (credits !== 3'd2) $display("FAIL bp_credits: got %0d want 2", credits); else n_pass++;
        drain_check("bp_drain");
    endtask

    task automatic test_bypass();
        offer(2'b10, 16'h3100);
        tick();
        offer(2'b10, 16'h3200);
        tick();
        vin = '0;
        #1;
        n_checks++; if (credits !== 3'd0) $display("FAIL byp_empty: got %0d want 0", credits); else n_pass++;
        bypass = 1'b1;
        offer(2'b01, 16'h0077);
        #1;
        n_checks++; if ({in_ready, stall} !== 2'b10) $display("FAIL byp_accept: got %b want 10", {in_ready, stall}); else n_pass++;
        tick();
        vin = '0;
        #1;
        n_checks++; if ({vout, credits} !== {2'b01, 3'd0}) $display("FAIL byp_out: got %b want 01000", {vout, credits}); else n_pass++;
        bypass = 1'b0;
        #1;
        n_checks++; if (in_ready !== 1'b0) $display("FAIL byp_off: got %b want 0", in_ready); else n_pass++;
        tick();
        drain_check("byp_drain");
    endtask

    task automatic test_reset_mid();
        reload = 1'b1;
        tick();
        reload = 1'b0;
        out_ready = 1'b0;
        offer(2'b11, 16'hC3C3);
        tick();
        vin = '0;
        #1;
        n_checks++; if (vout !== 2'b11) $display("FAIL rmid_held: got %b want 11", vout); else n_pass++;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({vout, data_out, credits} !== {2'b00, 16'h0000, 3'd4}) $display("FAIL rmid_drop: got %h want %h", {vout, data_out, credits}, {2'b00, 16'h0000, 3'd4});
        else n_pass++;
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        #1;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL rmid_ready: got %b want 1", in_ready); else n_pass++;
        tick();
    endtask

    initial begin
        repeat (2) @(negedge clk);
        test_reset();
        test_exhaustion();
        test_return();
        test_simultaneous();
        test_overflow();
        test_backpressure();
        test_bypass();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/slink_tx_credit_ctrl.md
# slink_tx_credit_ctrl

Credit-based flow-control gate on the serial-link TX path, between the link layer's per-channel phy output (`data_out_*`) and the physical layer's TX stage. It keeps a counter of free slots in the remote receiver's flow-control FIFO and registers each outgoing beat. A beat is released only when a credit is available. Returned credits arrive as single-cycle pulses from the RX side of the same link. Raw/calibration traffic bypasses credit accounting.

## Interface
- `phy_data_t`, default `logic`: per-channel phy word type.
- `NumChannels`, default 1: number of parallel phy channels.
- `NumCredits`, default 8: initial and maximum credit count; equals the remote `RecvFifoDepth`; must be ≥1.
- `CntWidth`, default `$clog2(NumCredits+1)` (localparam): credit counter width.
- `clk_i`, in, 1: clock.
- `rst_i`, in, 1: reset, asynchronous, active-high.
- `data_in_i`, in, `NumChannels × phy_data_t`: beat from the link layer.
- `data_in_valid_i`, in, `NumChannels`: per-channel valid; a beat is offered when any bit is set.
- `data_in_ready_o`, out, 1: common ready to the link layer.
- `data_out_o`, out, `NumChannels × phy_data_t`: registered beat to the phy.
- `data_out_valid_o`, out, `NumChannels`: registered per-channel valid mask.
- `data_out_ready_i`, in, 1: phy ready.
- `credit_return_i`, in, 1: one pulse returns one credit.
- `cfg_credit_bypass_i`, in, 1: raw mode; no credits consumed or required.
- `cfg_credit_reload_i`, in, 1: synchronous reload of the counter to `NumCredits`; clears the error flag.
- `credits_o`, out, `CntWidth`: current credit count.
- `credit_stall_o`, out, 1: a beat is offered but blocked only by zero credits.
- `credit_overflow_o`, out, 1: sticky; set when a return would exceed `NumCredits`.

## Operation
- Output stage: a single-entry register holding `out_valid_q` (`NumChannels` bits) and `out_data_q`.
- `space = (out_valid_q == '0) | data_out_ready_i`.
- `credit_ok = cfg_credit_bypass_i | (cnt_q != 0)`.
- `data_in_ready_o = space & credit_ok`. This output does not depend on `data_in_valid_i`.
- Accept: `|data_in_valid_i & data_in_ready_o`. On accept, load the register with `data_in_valid_i` and `data_in_i`, and set `consume = ~cfg_credit_bypass_i`.
- Drain: `data_out_ready_i` with `out_valid_q != 0` and no accept clears `out_valid_q`.
- Counter next value, with `ret = credit_return_i`:
  - If `consume & ret`, or neither: `cnt_q` is unchanged.
  - If `consume` only: `cnt_q - 1`. Never underflows, because `credit_ok` gates it.
  - If `ret` only and `cnt_q < NumCredits`: `cnt_q + 1`.
  - If `ret` only and `cnt_q == NumCredits`: counter saturates and `credit_overflow_o` is set.
- `cfg_credit_reload_i` has priority over consume and return in the same cycle:
  - counter becomes `NumCredits`;
  - overflow flag clears;
  - the output register is unaffected.
- `credit_stall_o = |data_in_valid_i & space & ~credit_ok`.
- A bypass toggle takes effect on the same cycle. A beat already in the register is not re-accounted.

## Timing
- Reset values:
  - `out_valid_q` = 0, so `data_out_valid_o` = 0;
  - `data_out_o` = 0;
  - `cnt_q` = `NumCredits`;
  - `credit_overflow_o` = 0;
  - `data_in_ready_o` = 1 once reset deasserts.
- Latency: 1 cycle from input accept to `data_out_valid_o`.
- Throughput: 1 beat per cycle while credits last and `data_out_ready_i` stays high.
- Ready-path rules:
  - `data_in_ready_o` depends combinationally on `data_out_ready_i` (pass-through ready).
  - No combinational path exists from `data_in_valid_i` to any ready.
- Credit timing:
  - A credit returned in cycle N is usable for an accept in cycle N+1.
  - At `cnt_q == 0`, a simultaneous return does not enable an accept in the same cycle.
- The output register holds its data stable while `data_out_valid_o != 0` and `data_out_ready_i == 0`.
- Reset asserted mid-transfer drops the held beat immediately, with no handshake.

## Structure
- No package types. `phy_data_t` is passed as a parameter, consistent with the other `slink_*` blocks.
- The output stage is built from the common-cells `stream_register` with `T = phy_data_t [NumChannels-1:0]`, plus a separately flopped valid mask. Its `rst_ni` is driven by `~rst_i`.
- The credit counter lives in this module; no further sub-modules.

## Test plan
- Credit exhaustion (`NumCredits = 4`): reset, then drive 6 back-to-back beats with `data_out_ready_i = 1` → 4 beats emerge on consecutive cycles; `credits_o` goes 4→0; `credit_stall_o = 1` while beats 5–6 wait.
- Credit return: from `cnt = 0` with a beat pending, pulse `credit_return_i` at cycle N → accept at N+1; `credits_o` reads 1 at N+1 and 0 at N+2.
- Simultaneous consume and return at `cnt = 2` → `cnt` stays 2; throughput 1 beat/cycle is sustained.
- Overflow: at `cnt = 4`, pulse return → `cnt` stays 4; `credit_overflow_o` = 1 and stays set; a `cfg_credit_reload_i` pulse clears it.
- Backpressure: `data_out_ready_i = 0` for 5 cycles with a beat held, data `0xA5` on channel 0 → output stable; `data_in_ready_o = 0`; only one credit consumed.
- Bypass: `cfg_credit_bypass_i = 1`, `cnt = 0`, valid mask `0b01` → beat accepted; output mask is `0b01`; `credits_o` stays 0.
